// File: rtl/lfsr_pattern_gen_if.sv
// Stimulus-side bundle of the BIST pattern generator: run control, seed load and pattern outputs.
// The generator drives the slave outputs; the BIST controller owns the master side.
interface lfsr_pattern_gen_if #(
  parameter int WIDTH     = 5,
  parameter int OUT_WIDTH = 4,
  parameter int CNT_W     = 16
);
  logic                 control_input;
  logic                 start;
  logic [CNT_W-1:0]     num_patterns;
  logic                 load;
  logic [WIDTH-1:0]     seed_in;
  logic [OUT_WIDTH-1:0] vector;
  logic [WIDTH-1:0]     state_out;
  logic [CNT_W-1:0]     pattern_count;
  logic                 busy;
  logic                 done;
  logic                 lockup;

  modport master (
    output control_input, start, num_patterns, load, seed_in,
    input  vector, state_out, pattern_count, busy, done, lockup
  );

  modport slave (
    input  control_input, start, num_patterns, load, seed_in,
    output vector, state_out, pattern_count, busy, done, lockup
  );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// Parametrised Fibonacci/Galois LFSR pattern source with seed load, zero-state recovery and run counter.
// Latency: 1 cycle from advance/load/start to outputs; no backpressure, control_input gates each advance.
module lfsr_pattern_gen #(
  parameter int               WIDTH     = 5,
  parameter int               OUT_WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS      = 5'b01001,
  parameter logic [WIDTH-1:0] SEED      = 5'b10010,
  parameter int               MODE      = 0,
  parameter int               CNT_W     = 16
) (
  input logic                 clock,
  input logic                 reset_internal_n,
  lfsr_pattern_gen_if.slave   bus
);

  // Encoding chosen so that bit 0 is busy and bit 1 is done straight from the flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       fsm_q;
  logic [WIDTH-1:0] x_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] target_q;
  logic             lockup_q;

  logic             adv;
  logic             zero_seed;
  logic             zero_adv;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    if (MODE == 0) begin
      r = {^(v & TAPS), v[WIDTH-1:1]};
    end else begin
      r[WIDTH-1] = v[0];
      for (int i = 0; i < WIDTH - 1; i++) begin
        r[i] = v[i+1] ^ (TAPS[i] & v[0]);
      end
    end
    return r;
  endfunction

  assign adv       = (fsm_q == RUN) && bus.control_input && !bus.load;
  assign zero_seed = bus.load && (bus.seed_in == '0);
  assign zero_adv  = adv && (x_q == '0);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_internal_n) begin
    if (!reset_internal_n) begin
      x_q      <= SEED;
      lockup_q <= 1'b0;
    end else begin
      if (bus.load) begin
        x_q <= zero_seed ? SEED : bus.seed_in;
      end else if (adv) begin
        x_q <= zero_adv ? SEED : lfsr_step(x_q);
      end
      if (zero_seed || zero_adv) begin
        lockup_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_internal_n) begin
    if (!reset_internal_n) begin
      fsm_q    <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          if (bus.start) begin
            target_q <= bus.num_patterns;
            cnt_q    <= '0;
            fsm_q    <= (bus.num_patterns == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // A load in RUN replaces the advance, so it is not counted.
          if (adv) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == target_q) begin
              fsm_q <= DONE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.vector        = x_q[OUT_WIDTH-1:0];
  assign bus.state_out     = x_q;
  assign bus.pattern_count = cnt_q;
  assign bus.busy          = fsm_q[0];
  assign bus.done          = fsm_q[1];
  assign bus.lockup        = lockup_q;

endmodule

// File: doc/lfsr_pattern_gen.md
# lfsr_pattern_gen

Parametrised LFSR test-pattern generator for the BIST input path: the next generation of the fixed 5-bit input LFSR. Width, feedback polynomial, seed, output slice and Fibonacci/Galois structure are set by parameters. Adds runtime seed loading, all-zero lock-up recovery, and a pattern-count run controller. A run applies exactly `num_patterns` vectors to the circuit under test, then signals `done` to the BIST controller.

## Interface
- `WIDTH`, 5: LFSR register width, 2..32.
- `OUT_WIDTH`, 4: width of `vector` (low bits of the register), 1..WIDTH.
- `TAPS`, 5'b01001: feedback mask, WIDTH bits; bit i=1 means register bit i is tapped.
- `SEED`, 5'b10010: reset/recovery value, WIDTH bits, must be non-zero.
- `MODE`, 0: 0 = Fibonacci, 1 = Galois.
- `CNT_W`, 16: width of the pattern counter.
- `clock` in 1: single clock, rising edge.
- `reset_internal_n` in 1: asynchronous, active-low reset.
- `control_input` in 1: step enable; advances the LFSR only while RUN.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `num_patterns` in CNT_W: number of advances in a run; sampled on the accepted `start`.
- `load` in 1: synchronous load of `seed_in` into the register, accepted in any state.
- `seed_in` in WIDTH: value written by `load`.
- `vector` out OUT_WIDTH: current pattern, equal to x[OUT_WIDTH-1:0].
- `state_out` out WIDTH: full LFSR register x.
- `pattern_count` out CNT_W: advances completed in the current or last run.
- `busy` out 1: FSM is in RUN.
- `done` out 1: FSM is in DONE.
- `lockup` out 1: sticky flag; set on any zero-state recovery.

## Operation
- Fibonacci advance: x <= {fb, x[WIDTH-1:1]}, with fb = XOR of x[i] over all i where TAPS[i]=1.
- Galois advance: x'[WIDTH-1] = x[0]; x'[i] = x[i+1] ^ (TAPS[i] & x[0]) for i < WIDTH-1.
- Priority each cycle: `load` first, then advance.
  - `load` with `seed_in`=0 loads SEED instead and sets `lockup`.
  - Advance is taken when state=RUN, `control_input`=1 and `load`=0.
  - If the register is ever all-zero when an advance is taken, it loads SEED instead and sets `lockup`.
- `lockup` clears only on reset.
- FSM states and transitions:
  - IDLE, reset state: `start` -> RUN; latch `num_patterns` as N; clear `pattern_count`. If N=0, go directly to DONE instead.
  - RUN: each advance increments `pattern_count`. When the increment makes `pattern_count`=N, go to DONE on that same edge.
  - RUN: `start` is ignored.
  - DONE: hold the register and `pattern_count`. `start` re-enters RUN with the same rules as from IDLE. The register is not reseeded; use `load` for a repeatable run.
- `load` in RUN: the load replaces the advance for that cycle. `pattern_count` does not increment.
- `load` and `start` in the same cycle: both take effect.

## Timing
- Reset values: x=SEED, `vector`=SEED[OUT_WIDTH-1:0], `state_out`=SEED, `pattern_count`=0, `busy`=0, `done`=0, `lockup`=0, FSM=IDLE.
- Reset assertion mid-run returns every output to its reset value immediately (asynchronous).
- Release of reset is synchronised by the environment.
- All outputs are registered. The new `vector` is visible the cycle after an advance or load edge.
- `start` to `busy`=1: 1 cycle.
- Final advance edge: `busy` falls and `done` rises on that edge, and `pattern_count`=N.
- N advances need at least N cycles with `control_input`=1. Gaps in `control_input` stretch the run without penalty.
- `pattern_count` never wraps inside a run, because N ≤ 2^CNT_W−1.

## Test plan
- Defaults, reset released; `start` with N=5 and `control_input`=1 held -> `vector` sequence 0010, 1001, 0100, 0010, 0001, 0000. `done`=1 and `pattern_count`=5 five cycles after `busy` rises.
- Defaults; `start` with N=31 and `control_input` held -> `state_out` returns to 10010 exactly after the 31st advance. No intermediate state repeats and none is 0.
- MODE=1, TAPS=5'b00100; `load` `seed_in`=00001, then one advance in RUN -> `state_out`=10100.
- `load` with `seed_in`=0 -> `state_out`=SEED on the next cycle and `lockup`=1. `lockup` stays 1 through further runs until reset.
- Run with N=10; toggle `control_input` 1,0,1,0…; assert `load` on the 3rd enabled cycle -> that cycle does not count. `done` arrives after 10 counted advances, and `start` during RUN has no effect.
- Assert `reset_internal_n`=0 mid-run, off a clock edge -> all outputs return to their reset values before the next edge. `start` with N=0 -> `done`=1 one cycle later and `pattern_count`=0.
